// File: rtl/glue_pkg.sv
// Shared definitions for the FPGA top-level glue: FSM states, default
// parameters and a width helper.
package glue_pkg;

  typedef enum logic [1:0] {
    S_ASSERT  = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_HOLD_CYCLES = 100;
  localparam int DEF_GAP_CYCLES  = 8;
  localparam int DEF_DIV         = 4;

  // Larger of two sizes, used to share one counter between hold and gap.
  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the async input; both stages clear on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: waits for end-of-startup, holds all resets, then releases
// channels 0..N_CH-1 one by one. Also produces a free-running clock enable.
module reset_seq
  import glue_pkg::*;
#(
  parameter int              N_CH        = DEF_N_CH,
  parameter int              HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int              GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int              DIV         = DEF_DIV,
  parameter logic [N_CH-1:0] RST_POL     = '1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        eos,
  input  logic                        req_reset,
  output logic [N_CH-1:0]             rst_out,
  output logic [$clog2(N_CH+1)-1:0]   stage,
  output logic                        done,
  output logic                        ce
);

  localparam int CH_W  = $clog2(N_CH + 1);
  localparam int CNT_W = $clog2(max(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam int DIV_W = $clog2(DIV + 1);

  localparam logic [CNT_W-1:0] HOLD_T = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_T  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_T  = DIV_W'(DIV - 1);
  localparam logic [CH_W-1:0]  LAST   = CH_W'(N_CH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] divcnt;
  logic             eos_s;

  sync2 u_eos_sync (
    .clk   (clk),
    .reset (reset),
    .d     (eos),
    .q     (eos_s)
  );

  // Sequencer FSM; losing eos or a soft request restarts from full assertion.
  always_ff @(posedge clk) begin
    if (!reset || !eos_s || req_reset) begin
      state   <= S_ASSERT;
      cnt     <= '0;
      stage   <= '0;
      done    <= 1'b0;
      rst_out <= RST_POL;
    end else begin
      case (state)
        S_ASSERT: begin
          if (cnt == HOLD_T) begin
            rst_out[0] <= ~RST_POL[0];
            stage      <= CH_W'(1);
            cnt        <= '0;
            if (N_CH == 1) begin
              state <= S_RUN;
              done  <= 1'b1;
            end else begin
              state <= S_RELEASE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (cnt == GAP_T) begin
            // stage doubles as the index of the next channel to release
            for (int i = 0; i < N_CH; i++)
              if (stage == CH_W'(i)) rst_out[i] <= ~RST_POL[i];
            stage <= stage + CH_W'(1);
            cnt   <= '0;
            if (stage == LAST) begin
              state <= S_RUN;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RUN: ;
        default: state <= S_ASSERT;
      endcase
    end
  end

  // Free-running divider; only the block reset restarts it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      divcnt <= '0;
      ce     <= 1'b0;
    end else begin
      ce     <= (divcnt == DIV_T);
      divcnt <= (divcnt == DIV_T) ? '0 : divcnt + DIV_W'(1);
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq: three parameter sets driven in lockstep.
module tb_reset_seq;

  typedef struct packed {
    logic [3:0] rst;
    logic [2:0] stage;
    logic       done;
    logic       ce;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic eos = 1'b0;
  logic req_reset = 1'b0;

  logic [3:0] rst_a;  logic [2:0] stage_a; logic done_a, ce_a;
  logic [0:0] rst_b;  logic [0:0] stage_b; logic done_b, ce_b;
  logic [2:0] rst_c;  logic [1:0] stage_c; logic done_c, ce_c;

  int vectors = 0;
  int miscompares = 0;

  // model state: eos history, edges of uninterrupted eos_s high, edges since reset
  logic s1 = 1'b0, s2 = 1'b0;
  int   rl = 0;
  int   k  = 0;

  exp_t qa[$], qb[$], qc[$];

  always #5 clk = ~clk;

  reset_seq #(.N_CH(4), .HOLD_CYCLES(100), .GAP_CYCLES(8), .DIV(4), .RST_POL(4'b1111)) ua (
    .clk(clk), .reset(reset), .eos(eos), .req_reset(req_reset),
    .rst_out(rst_a), .stage(stage_a), .done(done_a), .ce(ce_a));

  reset_seq #(.N_CH(1), .HOLD_CYCLES(1), .GAP_CYCLES(1), .DIV(1), .RST_POL(1'b1)) ub (
    .clk(clk), .reset(reset), .eos(eos), .req_reset(req_reset),
    .rst_out(rst_b), .stage(stage_b), .done(done_b), .ce(ce_b));

  reset_seq #(.N_CH(3), .HOLD_CYCLES(100), .GAP_CYCLES(8), .DIV(3), .RST_POL(3'b010)) uc (
    .clk(clk), .reset(reset), .eos(eos), .req_reset(req_reset),
    .rst_out(rst_c), .stage(stage_c), .done(done_c), .ce(ce_c));

  // Channel i is free once the run has lasted hold + i*gap edges.
  function automatic exp_t expv(int n, int hold, int gap, int div, logic [3:0] pol,
                                int run, int kk);
    exp_t e;
    int   st;
    st = 0;
    for (int i = 0; i < n; i++)
      if (run >= hold + i * gap) st++;
    e.rst = 4'b0;
    for (int i = 0; i < 4; i++)
      if (i < n) e.rst[i] = (i < st) ? ~pol[i] : pol[i];
    e.stage = 3'(st);
    e.done  = (st == n);
    e.ce    = (kk >= 1) && (kk % div == 0);
    return e;
  endfunction

  // Reference model: advances on every edge with the inputs the DUT sees.
  initial forever begin
    @(posedge clk);
    if (!reset) begin
      s1 = 1'b0; s2 = 1'b0; rl = 0; k = 0;
    end else begin
      if (!s2 || req_reset) rl = 0;
      else if (rl < 1000) rl++;
      s2 = s1;
      s1 = eos;
      k++;
    end
    qa.push_back(expv(4, 100, 8, 4, 4'b1111, rl, k));
    qb.push_back(expv(1, 1, 1, 1, 4'b0001, rl, k));
    qc.push_back(expv(3, 100, 8, 3, 4'b0010, rl, k));
  end

  task automatic chk(input string nm, input exp_t got, input exp_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got rst=%b stage=%0d done=%b ce=%b, expected rst=%b stage=%0d done=%b ce=%b",
               nm, $time, got.rst, got.stage, got.done, got.ce,
               exp.rst, exp.stage, exp.done, exp.ce);
    end
  endtask

  // Monitor: outputs are presented every cycle, compare on the falling edge.
  initial forever begin
    @(negedge clk);
    if (qa.size() > 0) begin
      exp_t ga, gb, gc;
      ga = '{rst: rst_a, stage: stage_a, done: done_a, ce: ce_a};
      gb = '{rst: {3'b0, rst_b}, stage: {2'b0, stage_b}, done: done_b, ce: ce_b};
      gc = '{rst: {1'b0, rst_c}, stage: {1'b0, stage_c}, done: done_c, ce: ce_c};
      chk("cfg_default", ga, qa.pop_front());
      chk("cfg_n1_div1", gb, qb.pop_front());
      chk("cfg_n3_pol010", gc, qc.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_req();
    req_reset = 1'b1;
    cyc(1);
    req_reset = 1'b0;
  endtask

  // Bounded wait on the reference model's run length.
  task automatic wait_rl(input int target, input string nm);
    int n;
    n = 0;
    while (rl != target && n < 500) begin
      cyc(1);
      n++;
    end
    if (rl != target) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_%s: run length %0d, required %0d", nm, rl, target);
    end
  endtask

  initial begin
    // power-up: reset low five edges, eos present at release
    cyc(5);
    reset = 1'b1;
    eos   = 1'b1;
    cyc(140);

    // soft reset from RUN
    pulse_req();
    cyc(120);

    // eos lost while two channels are out
    pulse_req();
    wait_rl(112, "stage2");
    eos = 1'b0;
    cyc(6);
    eos = 1'b1;
    cyc(140);

    // request and eos fall together, then a request mid-hold
    req_reset = 1'b1;
    eos       = 1'b0;
    cyc(1);
    req_reset = 1'b0;
    cyc(4);
    eos = 1'b1;
    wait_rl(50, "hold50");
    pulse_req();
    cyc(110);

    // block reset on a ce pulse, then mid-release
    cyc(30);
    begin
      int n;
      n = 0;
      while (k % 4 != 0 && n < 10) begin
        cyc(1);
        n++;
      end
    end
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    cyc(112);
    reset = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(140);

    // random soak
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      reset = 1'b1;
      req_reset = 1'b0;
      if (r < 3) reset = 1'b0;
      else if (r < 7) req_reset = 1'b1;
      else if (eos && r < 10) eos = 1'b0;
      else if (!eos && r > 800) eos = 1'b1;
      cyc(1);
    end
    reset = 1'b1;
    req_reset = 1'b0;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reset_seq.md
# reset_seq

Parametrised reset sequencer and clock-enable generator for the FPGA top-level glue. It waits for configuration end-of-startup, holds all downstream resets for a programmable time, then releases N reset channels one by one with a programmable gap. It re-runs the sequence on a soft-reset request or on loss of `eos`. A free-running divided clock-enable replaces fabric clock division.

## Interface
- `N_CH`, 4: number of reset channels (≥1).
- `HOLD_CYCLES`, 100: cycles of sampled `eos` high before channel 0 releases (≥1).
- `GAP_CYCLES`, 8: cycles between consecutive channel releases (≥1).
- `DIV`, 4: clock-enable period in cycles (≥1).
- `RST_POL`, all ones: per-channel asserted level; bit i = 1 means active-high output.

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-low block reset.
- `eos`  in  1  end-of-startup, asynchronous to `clk`.
- `req_reset`  in  1  soft-reset request, one-cycle pulse, synchronous.
- `rst_out`  out  N_CH  per-channel reset; asserted level is `RST_POL[i]`.
- `stage`  out  $clog2(N_CH+1)  number of channels currently released.
- `done`  out  1  high when all channels are released.
- `ce`  out  1  one-cycle enable every DIV cycles.

## Operation
- `eos` passes through a 2-flop synchronizer, giving `eos_s`. Both flops reset to 0.
- FSM states:
  - ASSERT: all channels asserted; `cnt` counts cycles.
  - RELEASE: `idx` = next channel to release; `cnt` counts the gap.
  - RUN: all channels released.
- ASSERT behaviour:
  - If `!eos_s`, `cnt` ← 0.
  - Else if `cnt == HOLD_CYCLES-1`: deassert channel 0, `stage` ← 1, `cnt` ← 0, go to RELEASE (or RUN if N_CH=1).
  - Otherwise `cnt`++.
- RELEASE behaviour:
  - When `cnt == GAP_CYCLES-1`: deassert channel `stage`, `stage`++, `cnt` ← 0.
  - After the last channel, go to RUN with `done` ← 1.
  - Otherwise `cnt`++.
- Abort: `!eos_s` or `req_reset` in any state sends the FSM to ASSERT.
  - Same edge: all channels asserted, `stage` ← 0, `done` ← 0, `cnt` ← 0.
  - If both occur together, the result is the same.
  - `req_reset` in ASSERT restarts the hold count.
- Release order is fixed, 0 → N_CH-1. Channels never deassert out of order.
- Clock-enable divider:
  - `divcnt` counts 0..DIV-1 and wraps.
  - `ce` ← (`divcnt == DIV-1`).
  - DIV=1 gives `ce` constantly high after the first edge out of reset.
  - The divider is free-running and unaffected by `eos` or `req_reset`.
- Widths:
  - `cnt`: $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1).
  - `divcnt`: $clog2(DIV+1).
  - All compares are unsigned. No counter exceeds its terminal value.

## Timing
- While `reset`=0 at an edge:
  - `rst_out` = `RST_POL` (all asserted), `stage`=0, `done`=0, `ce`=0.
  - FSM = ASSERT; `cnt`, `divcnt` and synchronizer flops = 0.
- `eos` rising is first sampled at edge e1, so `eos_s` is high after e2.
- Release edges:
  - Channel 0 releases after edge e2+HOLD_CYCLES.
  - Channel i releases after edge e2+HOLD_CYCLES+i·GAP_CYCLES.
  - `done` rises on the same edge as the last release.
- `req_reset` sampled at edge t:
  - All channels are asserted after t.
  - Channel 0 releases after t+HOLD_CYCLES (`eos_s` high).
- `eos` falling: all channels are asserted after the 3rd edge, counting from the first sampling edge.
- `ce`: first pulse after edge DIV following `reset` deassertion, then every DIV edges.
- `reset` asserted mid-sequence wins over everything on that edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `glue_pkg` holds:
  - the FSM state typedef (ASSERT, RELEASE, RUN);
  - the `max` width helper function;
  - the default parameter constants.
- Sub-module `sync2`: a 2-flop synchronizer with synchronous active-low reset, reused for `eos` and elsewhere in glue.
- The divider is inline in `reset_seq`, not a separate module.

## Test plan
1. Power-up with defaults: `reset` low 5 cycles, then high; `eos` rises at e0.
   - `rst_out`=4'b1111 until after e102.
   - Bits release at e102, e110, e118, e126; `done`=1 after e126.
   - `stage` steps 0→4.
2. `req_reset` pulse at t in RUN:
   - `rst_out`=4'hF and `done`=0 after t.
   - Bit0 releases after t+100.
3. `eos` dropped mid-RELEASE (stage=2): all channels asserted within 3 edges, `stage`=0. Re-raising `eos` replays the full sequence from HOLD.
4. Simultaneous `req_reset` and `eos` fall, plus `req_reset` during ASSERT at cnt=50: single clean restart, and channel 0 release delayed to a full 100 cycles after the request.
5. Parameter sweep {N_CH=1, HOLD=1, GAP=1, DIV=1} and {N_CH=3, RST_POL=3'b010, DIV=3}:
   - Release edges match the formula.
   - Deasserted levels equal ~`RST_POL` (3'b101).
   - `ce` period is 1 / 3 cycles.
6. `reset` asserted mid-sequence and during a `ce` pulse: all outputs return to reset values on that edge, and `ce` restarts with its first pulse DIV edges after release.
